apb_arbiter: RTL and testbench
==============================

# apb_arbiter

Shares one downstream APB completer port between N_REQ APB requesters with round-robin arbitration, one transfer at a time. The block sits between several bus masters (CPU bridge, DMA, debug port) and the APB converter/peripheral segment, and presents a fully APB-compliant completer face to each requester and a requester face downstream. Address, write data and direction are registered from the winner. Ready, read data and error are returned combinationally to the granted requester only.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 13, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width
- TIMEOUT, 255, ACCESS-phase cycle limit (used only with the watchdog compiled in)
- PCLK  in  1  single clock; all logic on rising edge
- PRESETn  in  1  reset, synchronous, active-low
- s_psel  in  N_REQ  per-requester PSEL
- s_penable  in  N_REQ  per-requester PENABLE
- s_pwrite  in  N_REQ  per-requester PWRITE
- s_paddr  in  N_REQ*ADDR_WIDTH  packed requester addresses, requester i at slice i
- s_pwdata  in  N_REQ*DATA_WIDTH  packed requester write data
- s_pready  out  N_REQ  per-requester PREADY
- s_pslverr  out  N_REQ  per-requester PSLVERR
- s_prdata  out  DATA_WIDTH  read data, broadcast to all requesters
- m_psel, m_penable, m_pwrite  out  1  downstream APB controls
- m_paddr  out  ADDR_WIDTH  downstream address
- m_pwdata  out  DATA_WIDTH  downstream write data
- m_pready, m_pslverr  in  1  downstream response
- m_prdata  in  DATA_WIDTH  downstream read data
- timeout_evt  out  1  one-cycle pulse on watchdog abort (present only with APB_ARB_TIMEOUT_EN)

## Operation
- FSM states: ST_IDLE, ST_SETUP, ST_ACCESS.
- Request: requester i is requesting while s_psel[i]=1, whether s_penable[i] is 0 or 1.
- Grant:
  - In ST_IDLE with any request, pick a winner by round-robin. Search starts at last_grant+1 mod N_REQ.
  - Register grant, m_paddr, m_pwrite and m_pwdata from the winner. Set m_psel=1 and go to ST_SETUP.
- ST_SETUP: set m_penable=1 and go to ST_ACCESS unconditionally.
- ST_ACCESS with m_pready=1:
  - s_pready[grant]=1 and s_pslverr[grant]=m_pslverr in the same cycle, combinationally.
  - Next edge: m_psel=0, m_penable=0, last_grant<=grant, go to ST_IDLE.
- ST_ACCESS with m_pready=0: hold all outputs.
- Non-granted requesters: s_pready=0 and s_pslverr=0 always. They keep waiting with PSEL/PENABLE held.
- s_prdata = m_prdata at all times; only the granted requester's PREADY qualifies it.
- Requester signals are not re-sampled after grant. A requester dropping PSEL mid-transfer is a protocol violation; the downstream transfer still completes.
- Reset values:
  - m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0.
  - s_pready=0, s_pslverr=0, timeout_evt=0.
  - state=ST_IDLE, last_grant=N_REQ-1, so requester 0 wins first.
- Reset mid-transfer: PRESETn=0 on any edge forces the reset values at that edge. The in-flight transfer is abandoned and no s_pready is issued.

## Timing
- Request seen in ST_IDLE at cycle 0 → m_psel=1 at cycle 1 → m_penable=1 at cycle 2.
- Earliest s_pready is cycle 2, when m_pready is 1 in the first ACCESS cycle.
- One mandatory ST_IDLE cycle follows every transfer, so back-to-back throughput is one transfer per 3 cycles minimum.
- Each m_pready wait cycle adds one cycle of latency.
- Simultaneous requests: round-robin order only, with no fixed priority. With all N_REQ requesting continuously, each requester is granted exactly once per N_REQ transfers.

## Configuration
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to ST_ACCESS and increments each ACCESS cycle with m_pready=0.
  - When the count equals TIMEOUT with m_pready=0, that cycle drives s_pready[grant]=1, s_pslverr[grant]=1 and timeout_evt=1.
  - Next edge: m_psel=0, m_penable=0, go to ST_IDLE.
  - In that abort cycle, s_prdata still follows m_prdata.
- Undefined: no counter, no timeout_evt port, and ST_ACCESS waits indefinitely.

## Structure
- apb_arb_pkg holds the state enum (ST_IDLE/ST_SETUP/ST_ACCESS) and the request-vector and grant-index typedefs derived from N_REQ.
- Sub-module apb_rr_picker: combinational round-robin selector. Inputs are the request vector and last_grant; outputs are the winner index and a valid flag.
- The FSM, datapath registers and watchdog live in apb_arbiter.

## Test plan
- Single requester 2 writes addr 0x010 data 0xDEADBEEF, m_pready=1 → m_psel at cycle 1, m_penable at cycle 2 with m_paddr=0x010, m_pwrite=1, m_pwdata=0xDEADBEEF; s_pready[2]=1 at cycle 2.
- Requesters 0..3 all request from reset, m_pready=1 → grant order 0,1,2,3,0; transfers start 3 cycles apart.
- Requester 1 reads, m_pready low 5 ACCESS cycles, m_prdata=0x12345678 with m_pslverr=1 → s_pready[1]=1 and s_pslverr[1]=1 once, s_prdata=0x12345678; no other s_pready asserted.
- PRESETn low during ST_ACCESS → next edge m_psel=0, m_penable=0, no s_pready; the next grant goes to requester 0.
- With APB_ARB_TIMEOUT_EN and TIMEOUT=4, m_pready held 0 → s_pready[g]=1, s_pslverr[g]=1 and timeout_evt=1 on the 5th ACCESS cycle; ST_IDLE next edge.
- Requester 3 granted while requester 0 asserts s_psel mid-transfer → requester 0 is served next, and s_pready[0] stays 0 until its own ACCESS.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types for the APB round-robin arbiter: FSM states and the request/grant types.
// Types are sized for the largest supported requester count (8).
package apb_arb_pkg;

  localparam int unsigned N_REQ_MAX = 8;
  localparam int unsigned GRANT_W   = $clog2(N_REQ_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } arb_state_e;

  typedef logic [N_REQ_MAX-1:0] req_vec_t;
  typedef logic [GRANT_W-1:0]   grant_idx_t;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin selector: the search starts one past last_grant and wraps
// modulo N_REQ. valid is low when nobody requests.
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  grant_idx_t       last_grant,
  output grant_idx_t       winner,
  output logic             valid
);

  req_vec_t   req_ext;
  grant_idx_t idx;

  always_comb begin
    req_ext = req_vec_t'(req);
    idx     = '0;
    winner  = '0;
    valid   = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = grant_idx_t'((32'(last_grant) + k) % N_REQ);
      if (!valid && req_ext[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB completer between N_REQ requesters, one transfer at a time.
// Optional ACCESS-phase watchdog with timeout_evt port: define APB_ARB_TIMEOUT_EN.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic [N_REQ-1:0]            s_psel,
  input  logic [N_REQ-1:0]            s_penable,
  input  logic [N_REQ-1:0]            s_pwrite,
  input  logic [N_REQ*ADDR_WIDTH-1:0] s_paddr,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_pwdata,
  output logic [N_REQ-1:0]            s_pready,
  output logic [N_REQ-1:0]            s_pslverr,
  output logic [DATA_WIDTH-1:0]       s_prdata,
  output logic                        m_psel,
  output logic                        m_penable,
  output logic                        m_pwrite,
  output logic [ADDR_WIDTH-1:0]       m_paddr,
  output logic [DATA_WIDTH-1:0]       m_pwdata,
  input  logic                        m_pready,
  input  logic                        m_pslverr,
`ifdef APB_ARB_TIMEOUT_EN
  output logic                        timeout_evt,
`endif
  input  logic [DATA_WIDTH-1:0]       m_prdata
);

  arb_state_e state_q, state_d;
  grant_idx_t grant_q, grant_d;
  grant_idx_t last_grant_q, last_grant_d;
  grant_idx_t winner;
  logic       win_valid;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;

  logic abort;
  logic resp;

  // Requester fields widened to the maximum count so the grant index addresses them exactly.
  logic [ADDR_WIDTH-1:0] addr_arr  [N_REQ_MAX];
  logic [DATA_WIDTH-1:0] wdata_arr [N_REQ_MAX];
  req_vec_t              wr_ext;

  for (genvar i = 0; i < N_REQ_MAX; i++) begin : g_unpack
    if (i < N_REQ) begin : g_live
      assign addr_arr[i]  = s_paddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = s_pwdata[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign addr_arr[i]  = '0;
      assign wdata_arr[i] = '0;
    end
  end
  assign wr_ext = req_vec_t'(s_pwrite);

  apb_rr_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req        (s_psel),
    .last_grant (last_grant_q),
    .winner     (winner),
    .valid      (win_valid)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SETUP) begin
      cnt_d = '0;
    end else if (state_q == ST_ACCESS && !m_pready) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign abort       = (state_q == ST_ACCESS) && !m_pready && (cnt_q == CntW'(TIMEOUT));
  assign timeout_evt = abort && PRESETn;
`else
  logic unused_timeout;
  assign unused_timeout = ^(32'(TIMEOUT));
  assign abort          = 1'b0;
`endif

  // Only PSEL defines a request; PENABLE carries no extra information here.
  logic unused_penable;
  assign unused_penable = ^s_penable;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          grant_d  = winner;
          paddr_d  = addr_arr[winner];
          pwdata_d = wdata_arr[winner];
          pwrite_d = wr_ext[winner];
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (m_pready || abort) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= grant_idx_t'(N_REQ - 1);
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
    end
  end

  // Response is steered to the granted requester only; suppressed while reset is applied.
  logic [N_REQ-1:0] grant_oh;
  assign grant_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
  assign resp      = PRESETn && (state_q == ST_ACCESS) && (m_pready || abort);
  assign s_pready  = resp ? grant_oh : '0;
  assign s_pslverr = (resp && (m_pslverr || abort)) ? grant_oh : '0;
  assign s_prdata  = m_prdata;

  assign m_psel    = psel_q;
  assign m_penable = penable_q;
  assign m_pwrite  = pwrite_q;
  assign m_paddr   = paddr_q;
  assign m_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios plus randomized transfers checked against a
// transaction-level round-robin model.
module tb_apb_arbiter;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 32;

  logic            PCLK;
  logic            PRESETn;
  logic [N-1:0]    s_psel, s_penable, s_pwrite;
  logic [N*AW-1:0] s_paddr;
  logic [N*DW-1:0] s_pwdata;
  logic [N-1:0]    s_pready, s_pslverr;
  logic [DW-1:0]   s_prdata;
  logic            m_psel, m_penable, m_pwrite;
  logic [AW-1:0]   m_paddr;
  logic [DW-1:0]   m_pwdata;
  logic            m_pready, m_pslverr;
  logic [DW-1:0]   m_prdata;
`ifdef APB_ARB_TIMEOUT_EN
  logic            timeout_evt;
`endif

  apb_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (255)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .s_psel      (s_psel),
    .s_penable   (s_penable),
    .s_pwrite    (s_pwrite),
    .s_paddr     (s_paddr),
    .s_pwdata    (s_pwdata),
    .s_pready    (s_pready),
    .s_pslverr   (s_pslverr),
    .s_prdata    (s_prdata),
    .m_psel      (m_psel),
    .m_penable   (m_penable),
    .m_pwrite    (m_pwrite),
    .m_paddr     (m_paddr),
    .m_pwdata    (m_pwdata),
    .m_pready    (m_pready),
    .m_pslverr   (m_pslverr),
`ifdef APB_ARB_TIMEOUT_EN
    .timeout_evt (timeout_evt),
`endif
    .m_prdata    (m_prdata)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending requests per requester and the last served requester.
  logic          pend   [N];
  logic [AW-1:0] r_addr [N];
  logic          r_wr   [N];
  logic [DW-1:0] r_data [N];
  int            last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int model_winner();
    for (int k = 1; k <= N; k++) begin
      if (pend[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic add_req(input int i, input logic [AW-1:0] a, input logic wr,
                         input logic [DW-1:0] d);
    pend[i]   = 1'b1;
    r_addr[i] = a;
    r_wr[i]   = wr;
    r_data[i] = d;
  endtask

  task automatic add_rand(input int i);
    add_req(i, AW'($urandom), 1'($urandom), $urandom);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      s_penable[i]            = pend[i] & s_psel[i];
      s_psel[i]               = pend[i];
      s_pwrite[i]             = r_wr[i];
      s_paddr[i*AW +: AW]     = r_addr[i];
      s_pwdata[i*DW +: DW]    = r_data[i];
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Called in an idle cycle with at least one request pending. mid_idx >= 0 makes that
  // requester start requesting during the SETUP cycle of this transfer.
  task automatic run_transfer(input int waits, input logic err, input int mid_idx);
    int w;
    w = model_winner();
    m_pready = 1'b0;
    drive_reqs();
    #1;
    chk("idle_psel", 64'(m_psel), 64'(0));
    chk("idle_pready", 64'(s_pready), 64'(0));
    step();
    if (mid_idx >= 0 && !pend[mid_idx]) add_rand(mid_idx);
    drive_reqs();
    #1;
    chk("setup_psel", 64'(m_psel), 64'(1));
    chk("setup_penable", 64'(m_penable), 64'(0));
    chk("setup_paddr", 64'(m_paddr), 64'(r_addr[w]));
    chk("setup_pwrite", 64'(m_pwrite), 64'(r_wr[w]));
    chk("setup_pwdata", 64'(m_pwdata), 64'(r_data[w]));
    chk("setup_pready", 64'(s_pready), 64'(0));
    for (int k = 0; k <= waits; k++) begin
      step();
      m_pready  = (k == waits);
      m_pslverr = err;
      m_prdata  = $urandom;
      drive_reqs();
      #1;
      chk("acc_psel", 64'(m_psel), 64'(1));
      chk("acc_penable", 64'(m_penable), 64'(1));
      chk("acc_paddr", 64'(m_paddr), 64'(r_addr[w]));
      chk("acc_prdata", 64'(s_prdata), 64'(m_prdata));
      chk("acc_pready", 64'(s_pready), (k == waits) ? 64'(onehot(w)) : 64'(0));
      chk("acc_pslverr", 64'(s_pslverr), (k == waits && err) ? 64'(onehot(w)) : 64'(0));
`ifdef APB_ARB_TIMEOUT_EN
      chk("acc_timeout_evt", 64'(timeout_evt), 64'(0));
`endif
    end
    pend[w] = 1'b0;
    last    = w;
    step();
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
  endtask

  initial begin
    int n_pend;
    int w;
    PRESETn   = 1'b0;
    s_psel    = '0;
    s_penable = '0;
    s_pwrite  = '0;
    s_paddr   = '0;
    s_pwdata  = '0;
    m_pready  = 1'b0;
    m_pslverr = 1'b0;
    m_prdata  = '0;
    for (int i = 0; i < N; i++) begin
      pend[i]   = 1'b0;
      r_addr[i] = '0;
      r_wr[i]   = 1'b0;
      r_data[i] = '0;
    end
    last = N - 1;

    step();
    step();
    #1;
    chk("rst_psel", 64'(m_psel), 64'(0));
    chk("rst_penable", 64'(m_penable), 64'(0));
    chk("rst_pwrite", 64'(m_pwrite), 64'(0));
    chk("rst_paddr", 64'(m_paddr), 64'(0));
    chk("rst_pwdata", 64'(m_pwdata), 64'(0));
    chk("rst_pready", 64'(s_pready), 64'(0));
    chk("rst_pslverr", 64'(s_pslverr), 64'(0));
    PRESETn = 1'b1;

    // Single write from requester 2.
    add_req(2, 13'h010, 1'b1, 32'hDEADBEEF);
    run_transfer(0, 1'b0, -1);

    // Requester 1 read with five wait states and an error response.
    add_req(1, 13'h1A4, 1'b0, 32'h0);
    run_transfer(5, 1'b1, -1);

    // Requester 3 alone; requester 0 arrives mid-transfer and is served next.
    add_req(3, 13'h0C0, 1'b1, 32'hA5A5_0003);
    run_transfer(1, 1'b0, 0);
    run_transfer(2, 1'b0, -1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      n_pend = 0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) add_rand(i);
        if (pend[i]) n_pend++;
      end
      if (n_pend == 0) add_rand(int'($urandom_range(0, N - 1)));
      run_transfer(int'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1);
    end

    // Reset during ACCESS: transfer abandoned, requester 0 wins afterwards.
    if (!pend[0]) add_rand(0);
    if (!pend[2]) add_rand(2);
    drive_reqs();
    step();
    drive_reqs();
    #1;
    chk("rstmid_setup_psel", 64'(m_psel), 64'(1));
    step();
    drive_reqs();
    #1;
    chk("rstmid_acc_penable", 64'(m_penable), 64'(1));
    PRESETn = 1'b0;
    #1;
    chk("rstmid_pready_during", 64'(s_pready), 64'(0));
    step();
    #1;
    chk("rstmid_psel", 64'(m_psel), 64'(0));
    chk("rstmid_penable", 64'(m_penable), 64'(0));
    chk("rstmid_pready", 64'(s_pready), 64'(0));
    PRESETn = 1'b1;
    last    = N - 1;
    run_transfer(0, 1'b0, -1);

    // All requesters requesting continuously: each served once per N transfers.
    for (int i = 0; i < N; i++) if (!pend[i]) add_rand(i);
    for (int t = 0; t < N + 1; t++) begin
      run_transfer(0, 1'b0, -1);
      add_rand(last);
    end

    // Drain the remaining requests.
    w = model_winner();
    while (w >= 0) begin
      run_transfer(int'($urandom_range(0, 2)), 1'b0, -1);
      w = model_winner();
    end
    drive_reqs();
    #1;
    chk("final_psel", 64'(m_psel), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
